// File: rtl/oai_cim_pkg.sv
// Shared types and width helpers for the OAI CIM bit-serial MAC.
package oai_cim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of one bit-plane sum: NUM_CH products of WEIGHT_W bits each.
  function automatic int unsigned plane_sum_w(input int unsigned weight_w,
                                              input int unsigned num_ch);
    return weight_w + $clog2(num_ch);
  endfunction

  // Accumulator width covering NUM_CH*(2^WEIGHT_W-1)*(2^INPUT_W-1).
  function automatic int unsigned acc_w(input int unsigned weight_w,
                                        input int unsigned input_w,
                                        input int unsigned num_ch);
    return weight_w + input_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/oai_prod_cell.sv
// OAI product cell: both OR terms tied to the same operands, giving
// prod = ~(w_n | {W{x_n}}) == w & {W{x}} for active-low inputs.
module oai_prod_cell #(
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic [WEIGHT_W-1:0] w_n,
  input  logic                x_n,
  output logic [WEIGHT_W-1:0] prod
);

  // Per-bit OR-AND-invert of active-low weight and broadcast activation bit.
  always_comb begin
    prod = ~(w_n | {WEIGHT_W{x_n}});
  end

endmodule

// File: rtl/oai_serial_mac.sv
// Bit-serial multi-channel MAC built from OAI product cells.
// Activation bit-planes arrive LSB first; each accepted plane is summed
// across channels and shift-accumulated.
// Optional build macro: OAI_SIGNED_X_EN (two's-complement activations; the
// MSB plane is subtracted).
module oai_serial_mac
  import oai_cim_pkg::*;
#(
  parameter  int unsigned WEIGHT_W = 4,
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned INPUT_W  = 4,
  localparam int unsigned ACC_W    = acc_w(WEIGHT_W, INPUT_W, NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH*WEIGHT_W-1:0] w_n,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic [NUM_CH-1:0]          x_n,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           result,
  output logic                       busy
);

  localparam int unsigned PS_W   = plane_sum_w(WEIGHT_W, NUM_CH);
  localparam int unsigned BIDX_W = $clog2(INPUT_W + 1);

  state_e                     state_q, state_d;
  logic [NUM_CH*WEIGHT_W-1:0] w_n_q, w_n_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [BIDX_W-1:0]          bit_idx_q, bit_idx_d;

  logic [WEIGHT_W-1:0]        prod [NUM_CH];
  logic [PS_W-1:0]            plane_sum;
  logic [ACC_W-1:0]           plane_term;
  logic                       beat;
  logic                       last_beat;

  // One OAI cell per channel, fed from the latched weights.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cell
    oai_prod_cell #(
      .WEIGHT_W(WEIGHT_W)
    ) u_cell (
      .w_n (w_n_q[k*WEIGHT_W +: WEIGHT_W]),
      .x_n (x_n[k]),
      .prod(prod[k])
    );
  end

  // Adder tree: unsigned sum of all channel products for this plane.
  always_comb begin
    plane_sum = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      plane_sum = plane_sum + PS_W'(prod[k]);
    end
    plane_term = ACC_W'(plane_sum) << bit_idx_q;
  end

  // Next-state, accumulate and weight-latch logic.
  always_comb begin
    state_d   = state_q;
    w_n_d     = w_n_q;
    acc_d     = acc_q;
    bit_idx_d = bit_idx_q;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          w_n_d     = w_n;
          acc_d     = '0;
          bit_idx_d = '0;
        end
      end
      BUSY: begin
        beat      = bit_valid;
        last_beat = (bit_idx_q == BIDX_W'(INPUT_W - 1));
        if (beat) begin
`ifdef OAI_SIGNED_X_EN
          // The MSB plane carries negative weight in two's complement.
          if (last_beat) acc_d = acc_q - plane_term;
          else           acc_d = acc_q + plane_term;
`else
          acc_d = acc_q + plane_term;
`endif
          bit_idx_d = bit_idx_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w_n_q     <= '0;
      acc_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      w_n_q     <= w_n_d;
      acc_q     <= acc_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    bit_ready = (state_q == BUSY);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    result    = acc_q;
  end

endmodule

// File: tb/tb_oai_serial_mac.sv
// Directed self-checking bench for oai_serial_mac (default 4/4/4 parameters).
module tb_oai_serial_mac;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] w_n;
  logic        bit_valid;
  logic        bit_ready;
  logic [3:0]  x_n;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  oai_serial_mac #(
    .WEIGHT_W(4),
    .NUM_CH  (4),
    .INPUT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .w_n      (w_n),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .x_n      (x_n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low bit-plane b of four packed 4-bit activations.
  function automatic logic [3:0] plane_n(input logic [15:0] at, input int b);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = ~at[4*k + b];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; x_n = 4'hF; w_n = 16'hFFFF;
    step();
    step();
    rst = 1'b0;
  endtask

  // Starts an op and feeds planes until out_valid (bounded). cyc counts
  // edges after the start edge until out_valid is seen.
  task automatic drive_op(input logic [15:0] wt, input logic [15:0] at,
                          input bit bubbles, input bit clobber_w,
                          output int cyc);
    int b;
    bit bv;
    b = 0;
    start = 1'b1;
    w_n = ~wt;
    step();
    start = 1'b0;
    if (clobber_w) w_n = 16'hFFFF;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      bv = !bubbles || (cyc % 2 == 0);
      bit_valid = bv;
      x_n = plane_n(at, b > 3 ? 3 : b);
      step();
      cyc++;
      if (bv) b++;
    end
    bit_valid = 1'b0;
    x_n = 4'hF;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 10'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_bit_ready got=%b exp=0", bit_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_dot_product();
    int cyc;
    do_reset();
    out_ready = 1'b1;
    drive_op(16'hF053, 16'h4321, 1'b0, 1'b0, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL dot_latency got=%0d exp=4", cyc); end
    checks++; if (result !== 10'd73) begin errors++; $display("FAIL dot_result got=%0d exp=73", result); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL dot_bit_ready_done got=%b exp=0", bit_ready); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dot_busy_after got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dot_out_valid_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_max_unsigned();
    int cyc;
    do_reset();
    out_ready = 1'b1;
    drive_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, cyc);
    checks++; if (result !== 10'd900) begin errors++; $display("FAIL max_result got=%0d exp=900", result); end
    step();
  endtask

  task automatic test_bubbles_backpressure();
    int cyc;
    do_reset();
    out_ready = 1'b0;
    drive_op(16'hF053, 16'h4321, 1'b1, 1'b0, cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL bub_latency got=%0d exp=7", cyc); end
    checks++; if (result !== 10'd73) begin errors++; $display("FAIL bub_result got=%0d exp=73", result); end
    start = 1'b1; bit_valid = 1'b1; w_n = 16'h0000; x_n = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (result !== 10'd73) begin errors++; $display("FAIL hold_result[%0d] got=%0d exp=73", i, result); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d] got=%b exp=1", i, busy); end
    end
    start = 1'b0; bit_valid = 1'b0; x_n = 4'hF; out_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bub_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    do_reset();
    out_ready = 1'b1;
    start = 1'b1; w_n = ~16'hF053;
    step();
    start = 1'b0;
    bit_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      x_n = plane_n(16'h4321, b);
      step();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 10'd0) begin errors++; $display("FAIL mrst_result got=%0d exp=0", result); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL mrst_bit_ready got=%b exp=0", bit_ready); end
    drive_op(16'hF053, 16'h4321, 1'b0, 1'b0, cyc);
    checks++; if (result !== 10'd73) begin errors++; $display("FAIL mrst_rerun_result got=%0d exp=73", result); end
    step();
  endtask

  task automatic test_weight_isolation();
    int cyc;
    do_reset();
    out_ready = 1'b1;
    drive_op(16'hF053, 16'h4321, 1'b0, 1'b1, cyc);
    checks++; if (result !== 10'd73) begin errors++; $display("FAIL wiso_result got=%0d exp=73", result); end
    step();
  endtask

  task automatic test_signed_x();
    int cyc;
    logic [9:0] exp_r;
`ifdef OAI_SIGNED_X_EN
    exp_r = 10'h3F1;
`else
    exp_r = 10'd225;
`endif
    do_reset();
    out_ready = 1'b1;
    drive_op(16'h000F, 16'h000F, 1'b0, 1'b0, cyc);
    checks++; if (result !== exp_r) begin errors++; $display("FAIL signed_x_result got=%h exp=%h", result, exp_r); end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; w_n = 16'hFFFF; bit_valid = 1'b0;
    x_n = 4'hF; out_ready = 1'b0;
    test_reset();
    test_dot_product();
    test_max_unsigned();
    test_bubbles_backpressure();
    test_mid_reset();
    test_weight_isolation();
    test_signed_x();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
